// File: rtl/tick_gen_multi.sv
// tick_gen_multi: multi-channel, run-time programmable strobe generator.
// Latency: PULSE/BUSY are registered; a channel pulses on its P-th enabled edge after a counter clear.
// Backpressure: none; EN low freezes a channel's counter and suppresses PULSE, nothing is queued.
//
// Ports:
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   EN[NUM_CH]          per-channel count enable
//   MODE[NUM_CH]        0 = periodic, 1 = one-shot (change clears the channel)
//   TRIG[NUM_CH]        one-shot start strobe (ignored while busy or in periodic mode)
//   SYNC                clears every channel counter for phase alignment
//   LOAD_MASK[NUM_CH]   channels whose period is replaced by LOAD_VAL
//   LOAD_VAL[CNT_W]     shared new period value; 0 idles the channel
//   PULSE[NUM_CH]       single-cycle strobe per channel
//   BUSY[NUM_CH]        channel counting toward a pulse
module tick_gen_multi #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 17,
  // Must fit in CNT_W bits; it is truncated to CNT_W otherwise.
  parameter int DEFAULT_PERIOD = 100000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] EN,
  input  logic [NUM_CH-1:0] MODE,
  input  logic [NUM_CH-1:0] TRIG,
  input  logic              SYNC,
  input  logic [NUM_CH-1:0] LOAD_MASK,
  input  logic [CNT_W-1:0]  LOAD_VAL,
  output logic [NUM_CH-1:0] PULSE,
  output logic [NUM_CH-1:0] BUSY
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;
    logic             pulse_q;
    logic             busy_q;

    logic [CNT_W-1:0] per_m1;
    logic [CNT_W-1:0] per_nxt;
    logic             per_nz;
    logic             term;
    logic             mode_chg;
    logic             clr;

    // A zero period makes per_m1 all-ones, but every count path is gated
    // by per_nz, so the counter can never run up to it.
    assign per_m1   = per_q - ONE;
    assign per_nz   = (per_q != '0);
    assign term     = (cnt_q == per_m1);
    assign mode_chg = (MODE[i] != mode_q);
    assign clr      = LOAD_MASK[i] | SYNC | mode_chg;
    // Period in force after this edge; periodic BUSY follows the new value on a load.
    assign per_nxt  = LOAD_MASK[i] ? LOAD_VAL : per_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        per_q   <= DEF_P;
        cnt_q   <= '0;
        mode_q  <= MODE[i];
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
      end else if (clr) begin
        // Load, SYNC and mode change all restart the channel; load and
        // SYNC on the same edge simply both take effect.
        if (LOAD_MASK[i]) per_q <= LOAD_VAL;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
        if (mode_chg) begin
          mode_q <= MODE[i];
          busy_q <= 1'b0;
        end else if (mode_q) begin
          busy_q <= 1'b0;
        end else begin
          busy_q <= EN[i] && (per_nxt != '0);
        end
      end else if (mode_q) begin
        // One-shot: TRIG arms the channel, P enabled edges later it fires once.
        pulse_q <= 1'b0;
        if (!busy_q) begin
          if (TRIG[i] && EN[i] && per_nz) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
          end
        end else if (EN[i]) begin
          if (term) begin
            cnt_q   <= '0;
            pulse_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
      end else begin
        // Periodic: free-running while enabled with a non-zero period.
        busy_q  <= EN[i] && per_nz;
        pulse_q <= 1'b0;
        if (EN[i] && per_nz) begin
          if (term) begin
            cnt_q   <= '0;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
      end
    end

    assign PULSE[i] = pulse_q;
    assign BUSY[i]  = busy_q;
  end

endmodule
